out_display_driver: RTL and testbench



---
 rtl/sap1_display_pkg.sv | 44 ++++
 rtl/bin_to_bcd_seq.sv | 82 ++++++++
 rtl/out_display_driver.sv | 160 ++++++++++++++++
 tb/tb_out_display_driver.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap1_display_pkg.sv
// Shared definitions for the output display driver.
//   - conv_state_t : double-dabble converter state encoding (IDLE/SHIFT/COMMIT)
//   - SEG_*        : active-low 7-segment codes, bit order {g,f,e,d,c,b,a}
//   - digit_to_seg : BCD digit to segment pattern; codes 10-15 map to blank
// Optional feature macro used by the top level: LEADING_ZERO_BLANK_EN.
package sap1_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic logic [6:0] digit_to_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter, one binary bit per clock.
// Ports:
//   clk_i, rst_i   : clock, synchronous active-high reset
//   start_i        : request a conversion of data_i
//   data_i         : binary value to convert (WIDTH bits)
//   busy_o         : converter is not idle
//   done_o         : high for the COMMIT cycle; bcd_o holds the result then
//   bcd_o          : BCD scratch, digit i in bits [4i+3:4i]
//   state_o        : current FSM state (debug visibility)
// Handshake: start_i is accepted on any edge where the state is IDLE or
// COMMIT; data_i is captured on that edge. In SHIFT start_i is ignored, so
// the caller must hold requests itself while busy.
module bin_to_bcd_seq
  import sap1_display_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [WIDTH-1:0]      data_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output conv_state_t           state_o
);

  localparam int CW = $clog2(WIDTH + 1);

  conv_state_t          state_q;
  logic [WIDTH-1:0]     bin_q;
  logic [4*DIGITS-1:0]  bcd_q;
  logic [CW-1:0]        cnt_q;
  logic [4*DIGITS-1:0]  bcd_adj;

  // Add-3 correction on every nibble >= 5 before the shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_COMMIT: begin
          if (start_i) begin
            bin_q   <= data_i;
            bcd_q   <= '0;
            cnt_q   <= CW'(WIDTH);
            state_q <= ST_SHIFT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_SHIFT: begin
          {bcd_q, bin_q} <= {bcd_adj[4*DIGITS-2:0], bin_q, 1'b0};
          cnt_q          <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= ST_COMMIT;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = (state_q == ST_COMMIT);
  assign bcd_o   = bcd_q;
  assign state_o = state_q;

endmodule

// File: rtl/out_display_driver.sv
// Output register reader: converts the loaded value to decimal and scans it
// onto a multiplexed common-anode 7-segment display.
// Ports:
//   mclk        : system clock
//   i_reset     : synchronous active-high reset
//   i_update    : single-cycle strobe, output register just loaded
//   i_data      : output register contents (WIDTH bits)
//   o_busy      : conversion in progress
//   o_anode     : active-low one-hot digit select, bit 0 = least significant
//   o_segments  : active-low segments {g,f,e,d,c,b,a}
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros
// (digit 0 always shown).
module out_display_driver
  import sap1_display_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 1024
) (
  input  logic              mclk,
  input  logic              i_reset,
  input  logic              i_update,
  input  logic [WIDTH-1:0]  i_data,
  output logic              o_busy,
  output logic [DIGITS-1:0] o_anode,
  output logic [6:0]        o_segments
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int DW = $clog2(SCAN_DIV);

  logic                 conv_busy;
  logic                 conv_done;
  logic [4*DIGITS-1:0]  conv_bcd;
  conv_state_t          conv_state;
  logic                 conv_start;
  logic [WIDTH-1:0]     conv_data;

  logic                 pend_q;
  logic [WIDTH-1:0]     pend_data_q;
  logic [4*DIGITS-1:0]  buf_q;
  logic [DW-1:0]        div_q;
  logic [IW-1:0]        idx_q;
  logic [DIGITS-1:0]    anode_d;
  logic [6:0]           seg_d;
  logic [3:0]           cur_digit;
  logic                 cur_blank;

  bin_to_bcd_seq #(
    .WIDTH  (WIDTH),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk_i   (mclk),
    .rst_i   (i_reset),
    .start_i (conv_start),
    .data_i  (conv_data),
    .busy_o  (conv_busy),
    .done_o  (conv_done),
    .bcd_o   (conv_bcd),
    .state_o (conv_state)
  );

  // In IDLE a fresh strobe wins over a stale pending value. In COMMIT only
  // the pending value restarts the engine; a strobe landing on the COMMIT
  // edge is parked in the pending register instead.
  always_comb begin
    conv_start = 1'b0;
    conv_data  = pend_data_q;
    if (conv_state == ST_IDLE) begin
      conv_start = i_update | pend_q;
      if (i_update) conv_data = i_data;
    end else if (conv_state == ST_COMMIT) begin
      conv_start = pend_q;
    end
  end

  always_ff @(posedge mclk) begin
    if (i_reset) begin
      pend_q      <= 1'b0;
      pend_data_q <= '0;
    end else if (conv_busy && i_update) begin
      pend_q      <= 1'b1;
      pend_data_q <= i_data;
    end else if (conv_start) begin
      pend_q      <= 1'b0;
    end
  end

  always_ff @(posedge mclk) begin
    if (i_reset) begin
      buf_q <= '0;
    end else if (conv_done) begin
      buf_q <= conv_bcd;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q;
  logic [DIGITS-1:0] blank_d;
  logic              seen_nz;

  // A digit is blank when it and every digit above it are zero.
  always_comb begin
    blank_d = '0;
    seen_nz = 1'b0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (conv_bcd[4*i +: 4] != 4'd0) seen_nz = 1'b1;
      blank_d[i] = ~seen_nz;
    end
  end

  // Reset mask matches a zero buffer.
  always_ff @(posedge mclk) begin
    if (i_reset) begin
      blank_q    <= '1;
      blank_q[0] <= 1'b0;
    end else if (conv_done) begin
      blank_q <= blank_d;
    end
  end
`endif

  always_comb begin
    anode_d   = '1;
    cur_digit = 4'd0;
    cur_blank = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        anode_d[i] = 1'b0;
        cur_digit  = buf_q[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
        cur_blank  = blank_q[i];
`endif
      end
    end
    seg_d = cur_blank ? SEG_BLANK : digit_to_seg(cur_digit);
  end

  // Anode and segments load on the same edge so they never disagree.
  always_ff @(posedge mclk) begin
    if (i_reset) begin
      div_q      <= '0;
      idx_q      <= '0;
      o_anode    <= '1;
      o_segments <= SEG_BLANK;
    end else begin
      if (div_q == DW'(SCAN_DIV - 1)) begin
        div_q <= '0;
        idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
      end else begin
        div_q <= div_q + DW'(1);
      end
      o_anode    <= anode_d;
      o_segments <= seg_d;
    end
  end

  assign o_busy = conv_busy;

endmodule

// File: tb/tb_out_display_driver.sv
// Self-checking bench for out_display_driver (WIDTH=8, DIGITS=3, SCAN_DIV=4).
module tb_out_display_driver;

  localparam int WIDTH    = 8;
  localparam int DIGITS   = 3;
  localparam int SCAN_DIV = 4;

  logic              mclk = 1'b0;
  logic              i_reset;
  logic              i_update;
  logic [WIDTH-1:0]  i_data;
  logic              o_busy;
  logic [DIGITS-1:0] o_anode;
  logic [6:0]        o_segments;

  int n_checks = 0;
  int n_fail   = 0;
  logic [20:0] exp_q[$];

  always #5 mclk = ~mclk;

  out_display_driver #(
    .WIDTH    (WIDTH),
    .DIGITS   (DIGITS),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .mclk       (mclk),
    .i_reset    (i_reset),
    .i_update   (i_update),
    .i_data     (i_data),
    .o_busy     (o_busy),
    .o_anode    (o_anode),
    .o_segments (o_segments)
  );

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Expected display {digit2, digit1, digit0} for a value.
  function automatic logic [20:0] model(input int v);
    int d0, d1, d2;
    logic [6:0] s0, s1, s2;
    d0 = v % 10;
    d1 = (v / 10) % 10;
    d2 = (v / 100) % 10;
    s0 = ref_seg(d0);
    s1 = ref_seg(d1);
    s2 = ref_seg(d2);
`ifdef LEADING_ZERO_BLANK_EN
    if (d2 == 0) s2 = 7'h7F;
    if (d2 == 0 && d1 == 0) s1 = 7'h7F;
`endif
    return {s2, s1, s0};
  endfunction

  function automatic int anode_slot(input logic [2:0] an);
    case (an)
      3'b110:  return 0;
      3'b101:  return 1;
      3'b011:  return 2;
      default: return -1;
    endcase
  endfunction

  task automatic step();
    @(negedge mclk);
  endtask

  // Gather one full scan rotation (12 samples cover all three digits).
  task automatic scan_once(output logic [20:0] got, output bit ok);
    bit [2:0] seen;
    int s;
    got  = '1;
    ok   = 1'b1;
    seen = '0;
    for (int k = 0; k < 12; k++) begin
      step();
      s = anode_slot(o_anode);
      if (s < 0) ok = 1'b0;
      else begin
        got[7*s +: 7] = o_segments;
        seen[s] = 1'b1;
      end
    end
    if (seen != 3'b111) ok = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] e;
    logic [2:0]  exp_an;
    int slot;
    bit busy_bad;
    i_reset  = 1'b1;
    i_update = 1'b0;
    i_data   = '0;
    repeat (3) step();
    n_checks++;
    if (o_anode !== 3'b111) begin
      n_fail++; $display("FAIL reset_anode: got %b expected 111", o_anode);
    end
    n_checks++;
    if (o_segments !== 7'h7F) begin
      n_fail++; $display("FAIL reset_segments: got %h expected 7f", o_segments);
    end
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b expected 0", o_busy);
    end
    exp_q.push_back(model(0));
    i_reset = 1'b0;
    e = exp_q.pop_front();
    busy_bad = 1'b0;
    for (int k = 0; k < 24; k++) begin
      step();
      slot   = (k / SCAN_DIV) % DIGITS;
      exp_an = ~(3'b001 << slot);
      if (o_busy !== 1'b0) busy_bad = 1'b1;
      n_checks++;
      if (o_anode !== exp_an) begin
        n_fail++; $display("FAIL scan_anode[%0d]: got %b expected %b", k, o_anode, exp_an);
      end
      n_checks++;
      if (o_segments !== e[7*slot +: 7]) begin
        n_fail++; $display("FAIL scan_segments[%0d]: got %h expected %h", k, o_segments, e[7*slot +: 7]);
      end
    end
    n_checks++;
    if (busy_bad) begin
      n_fail++; $display("FAIL idle_busy: got busy=1 expected 0 while idle");
    end
  endtask

  task automatic test_convert(input int v);
    logic [20:0] got, e;
    bit ok;
    int cnt;
    i_data   = WIDTH'(v);
    i_update = 1'b1;
    exp_q.push_back(model(v));
    step();
    i_update = 1'b0;
    cnt = 0;
    while (o_busy === 1'b1 && cnt < 50) begin
      cnt++;
      step();
    end
    n_checks++;
    if (cnt != WIDTH + 1) begin
      n_fail++; $display("FAIL busy_len(%0d): got %0d cycles expected %0d", v, cnt, WIDTH + 1);
    end
    scan_once(got, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== e) begin
      n_fail++; $display("FAIL display(%0d): got %h (scan_ok=%0d) expected %h", v, got, ok, e);
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] got, e100, e;
    bit ok;
    int s;
    i_data   = 8'd100;
    i_update = 1'b1;
    exp_q.push_back(model(100));
    exp_q.push_back(model(199));
    step();
    e100 = exp_q.pop_front();
    for (int n = 0; n < 18; n++) begin
      if (n == 2) begin
        i_data = 8'd42; i_update = 1'b1;
      end else if (n == 4) begin
        i_data = 8'd199; i_update = 1'b1;
      end else begin
        i_update = 1'b0;
      end
      n_checks++;
      if (o_busy !== 1'b1) begin
        n_fail++; $display("FAIL b2b_busy[%0d]: got %b expected 1", n, o_busy);
      end
      if (n >= 10) begin
        s = anode_slot(o_anode);
        n_checks++;
        if (s < 0) begin
          n_fail++; $display("FAIL b2b_anode[%0d]: got %b expected one-hot low", n, o_anode);
        end else if (o_segments !== e100[7*s +: 7]) begin
          n_fail++; $display("FAIL b2b_first[%0d]: got %h expected %h", n, o_segments, e100[7*s +: 7]);
        end
      end
      step();
    end
    i_update = 1'b0;
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++; $display("FAIL b2b_busy_end: got %b expected 0", o_busy);
    end
    scan_once(got, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== e) begin
      n_fail++; $display("FAIL b2b_final: got %h (scan_ok=%0d) expected %h", got, ok, e);
    end
  endtask

  task automatic test_reset_mid_conversion();
    logic [20:0] got, e;
    bit ok;
    bit busy_bad;
    i_data   = 8'd123;
    i_update = 1'b1;
    exp_q.push_back(model(0));
    step();
    i_update = 1'b0;
    step();
    step();
    step();
    i_reset = 1'b1;
    step();
    n_checks++;
    if (o_anode !== 3'b111 || o_segments !== 7'h7F) begin
      n_fail++; $display("FAIL midreset_outputs: got %b/%h expected 111/7f", o_anode, o_segments);
    end
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_busy: got %b expected 0", o_busy);
    end
    i_reset  = 1'b0;
    busy_bad = 1'b0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (o_busy !== 1'b0) busy_bad = 1'b1;
    end
    n_checks++;
    if (busy_bad) begin
      n_fail++; $display("FAIL midreset_no_commit: got busy=1 expected 0 after abort");
    end
    scan_once(got, ok);
    e = exp_q.pop_front();
    n_checks++;
    if (!ok || got !== e) begin
      n_fail++; $display("FAIL midreset_display: got %h (scan_ok=%0d) expected %h", got, ok, e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_reset  = 1'b1;
    i_update = 1'b0;
    i_data   = '0;
    test_reset();
    test_convert(255);
    test_convert(7);
    test_convert(0);
    for (int r = 0; r < 3; r++) test_convert(int'($urandom_range(0, 255)));
    test_back_to_back();
    test_reset_mid_conversion();
    test_convert(90);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
